// File: rtl/cmd_dispatch_ctrl.sv
// Command dispatcher: latches a command code, runs the matching handler, merges its status and enforces a timeout.
// Optional statistics counters are built only when CMD_DISPATCH_STATS_EN is defined.
module cmd_dispatch_ctrl #(
  parameter int unsigned N_HANDLERS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned TMR_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           rx_tdata,
  input  logic                  command_le,
  input  logic                  run_cmd_sm,
  input  logic [N_HANDLERS-1:0] handler_running,
  input  logic [N_HANDLERS-1:0] handler_done,
  output logic [N_HANDLERS-1:0] run_handler,
  output logic [N_HANDLERS-1:0] handler_abort,
  output logic                  cmd_sm_running,
  output logic                  cmd_sm_done,
  output logic                  cmd_timeout,
  input  logic                  clr_stats,
  output logic [15:0]           illegal_cnt,
  output logic [15:0]           timeout_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_ILLEGAL,
    S_TIMEOUT,
    S_DONE,
    S_WAIT_DROP
  } state_e;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_e                  state_q;
  logic [31:0]             code_q;
  logic                    valid_q;
  logic [N_HANDLERS-1:0]   sel_q;
  logic                    run_prev_q;
  logic [TMR_W-1:0]        timer_q;
  logic [N_HANDLERS-1:0]   run_handler_q;
  logic [N_HANDLERS-1:0]   abort_q;
  logic                    running_q;
  logic                    done_q;
  logic                    timeout_q;

  logic                    dec_valid_c;
  logic [N_HANDLERS-1:0]   dec_sel_c;
  logic                    run_rise_c;
  logic                    done_hit_c;
  logic                    tmr_exp_c;
  logic                    sel_running_c;

  always_comb begin
    dec_valid_c   = (code_q[31:4] == 28'd0) && ({1'b0, code_q[3:0]} < 5'(N_HANDLERS));
    dec_sel_c     = dec_valid_c ? (N_HANDLERS'(1) << code_q[3:0]) : '0;
    run_rise_c    = run_cmd_sm & ~run_prev_q;
    done_hit_c    = |(handler_done & sel_q);
    tmr_exp_c     = (timer_q == TMR_LAST);
    sel_running_c = |(handler_running & sel_q);
  end

  // Code capture in any state; decoded selection is frozen outside IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
    end else begin
      if (command_le) code_q <= rx_tdata;
      if (state_q == S_IDLE) begin
        valid_q <= dec_valid_c;
        sel_q   <= dec_sel_c;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      run_prev_q    <= 1'b0;
      timer_q       <= '0;
      run_handler_q <= '0;
      abort_q       <= '0;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      run_prev_q    <= run_cmd_sm;
      run_handler_q <= '0;
      abort_q       <= '0;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      if (command_le) timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run_rise_c) begin
            if (valid_q) begin
              state_q       <= S_RUN;
              timer_q       <= '0;
              run_handler_q <= sel_q;
              running_q     <= sel_running_c;
            end else begin
              state_q <= S_ILLEGAL;
            end
          end
        end
        S_RUN: begin
          // Parser abandonment wins, then completion, then expiry.
          if (!run_cmd_sm) begin
            state_q <= S_IDLE;
          end else if (done_hit_c) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (tmr_exp_c) begin
            state_q   <= S_TIMEOUT;
            abort_q   <= sel_q;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            timer_q       <= timer_q + TMR_W'(1);
            run_handler_q <= sel_q;
            running_q     <= sel_running_c;
          end
        end
        S_ILLEGAL: begin
          if (!run_cmd_sm) state_q <= S_IDLE;
        end
        S_TIMEOUT: state_q <= S_WAIT_DROP;
        S_DONE:    state_q <= S_WAIT_DROP;
        S_WAIT_DROP: begin
          if (!run_cmd_sm) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign run_handler    = run_handler_q;
  assign handler_abort  = abort_q;
  assign cmd_sm_running = running_q;
  assign cmd_sm_done    = done_q;
  assign cmd_timeout    = timeout_q;

`ifdef CMD_DISPATCH_STATS_EN
  logic        illegal_evt_c;
  logic        timeout_evt_c;
  logic [15:0] illegal_cnt_q;
  logic [15:0] timeout_cnt_q;

  always_comb begin
    illegal_evt_c = (state_q == S_IDLE) && run_rise_c && !valid_q;
    timeout_evt_c = (state_q == S_RUN) && run_cmd_sm && !done_hit_c && tmr_exp_c;
  end

  // Saturating counters; a clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_cnt_q <= '0;
      timeout_cnt_q <= '0;
    end else if (clr_stats) begin
      illegal_cnt_q <= '0;
      timeout_cnt_q <= '0;
    end else begin
      if (illegal_evt_c && (illegal_cnt_q != 16'hFFFF)) illegal_cnt_q <= illegal_cnt_q + 16'd1;
      if (timeout_evt_c && (timeout_cnt_q != 16'hFFFF)) timeout_cnt_q <= timeout_cnt_q + 16'd1;
    end
  end

  assign illegal_cnt = illegal_cnt_q;
  assign timeout_cnt = timeout_cnt_q;
`else
  logic unused_clr_stats;
  assign unused_clr_stats = clr_stats;
  assign illegal_cnt      = 16'd0;
  assign timeout_cnt      = 16'd0;
`endif

endmodule

// File: tb/tb_cmd_dispatch_ctrl.sv
// Self-checking bench for cmd_dispatch_ctrl: directed scenarios plus random commands against a per-transaction model.
module tb_cmd_dispatch_ctrl;

  localparam int N  = 4;
  localparam int TO = 1000;
`ifdef CMD_DISPATCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   rx_tdata;
  logic          command_le;
  logic          run_cmd_sm;
  logic [N-1:0]  handler_running;
  logic [N-1:0]  handler_done;
  logic [N-1:0]  run_handler;
  logic [N-1:0]  handler_abort;
  logic          cmd_sm_running;
  logic          cmd_sm_done;
  logic          cmd_timeout;
  logic          clr_stats;
  logic [15:0]   illegal_cnt;
  logic [15:0]   timeout_cnt;

  int total = 0;
  int bad   = 0;
  int illegal_m = 0;
  int timeout_m = 0;
  bit tmo_m = 1'b0;

  always #5 clk = ~clk;

  cmd_dispatch_ctrl #(.N_HANDLERS(N), .TIMEOUT_CYCLES(TO), .TMR_W(16)) dut (
    .clk(clk), .reset(reset), .rx_tdata(rx_tdata), .command_le(command_le),
    .run_cmd_sm(run_cmd_sm), .handler_running(handler_running), .handler_done(handler_done),
    .run_handler(run_handler), .handler_abort(handler_abort), .cmd_sm_running(cmd_sm_running),
    .cmd_sm_done(cmd_sm_done), .cmd_timeout(cmd_timeout), .clr_stats(clr_stats),
    .illegal_cnt(illegal_cnt), .timeout_cnt(timeout_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_illegal_cnt"}, 32'(illegal_cnt), STATS ? 32'(illegal_m) : 32'd0);
    chk({tag, "_timeout_cnt"}, 32'(timeout_cnt), STATS ? 32'(timeout_m) : 32'd0);
  endtask

  // done_d / drop_d: edge index after run start at which done / run low are seen (0 = never).
  task automatic txn(input logic [31:0] code, input int done_d, input int drop_d,
                     input bit clr, input bit mid_le);
    bit           valid;
    logic [N-1:0] sel_m;
    logic [N-1:0] run_pat;
    int           e;
    int           kind;  // 0 illegal, 1 done, 2 timeout, 3 dropped
    int           last;
    int           dn;
    int           dr;
    valid = (code < 32'(N));
    sel_m = '0;
    for (int i = 0; i < N; i++) sel_m[i] = valid && (code == 32'(i));
    dn = (done_d > 0) ? done_d : 1 << 30;
    dr = (drop_d > 0) ? drop_d : 1 << 30;
    if (!valid) begin
      kind = 0; e = 0;
    end else if (dr <= dn && dr <= TO) begin
      kind = 3; e = dr;
    end else if (dn <= TO) begin
      kind = 1; e = dn;
    end else begin
      kind = 2; e = TO;
    end
    last = (kind == 0) ? 5 : e + 3;
    run_pat = N'($urandom);

    rx_tdata = code; command_le = 1'b1;
    tick;
    command_le = 1'b0; rx_tdata = $urandom;
    tmo_m = 1'b0;
    chk("tmo_clear_on_le", 32'(cmd_timeout), 32'(tmo_m));
    tick;
    run_cmd_sm = 1'b1; clr_stats = clr; handler_running = run_pat;
    tick;
    clr_stats = 1'b0;
    if (clr) begin
      illegal_m = 0; timeout_m = 0;
    end else if (!valid) begin
      illegal_m = (illegal_m == 65535) ? 65535 : illegal_m + 1;
    end

    for (int j = 0; j <= last; j++) begin
      chk("run_handler", 32'(run_handler), (valid && j < e) ? 32'(sel_m) : 32'd0);
      chk("cmd_sm_running", 32'(cmd_sm_running),
          32'(valid && j < e && ((run_pat & sel_m) != '0)));
      chk("cmd_sm_done", 32'(cmd_sm_done), 32'(j == e && (kind == 1 || kind == 2)));
      chk("handler_abort", 32'(handler_abort), (j == e && kind == 2) ? 32'(sel_m) : 32'd0);
      handler_done = N'($urandom) & ~sel_m;
      if (valid && done_d == j + 1) handler_done = handler_done | sel_m;
      if (drop_d == j + 1) run_cmd_sm = 1'b0;
      if (mid_le && j == 0) begin
        command_le = 1'b1; rx_tdata = 32'($urandom_range(0, N - 1));
      end else begin
        command_le = 1'b0;
      end
      tick;
    end
    if (kind == 2) begin
      tmo_m = 1'b1;
      if (!clr || 1'b1) timeout_m = (timeout_m == 65535) ? 65535 : timeout_m + 1;
    end
    run_cmd_sm = 1'b0; handler_done = '0; handler_running = '0; command_le = 1'b0;
    tick;
    tick;
    chk("cmd_timeout_end", 32'(cmd_timeout), 32'(tmo_m));
    chk_stats("end");
  endtask

  initial begin
    reset = 1'b1; rx_tdata = '0; command_le = 1'b0; run_cmd_sm = 1'b0;
    handler_running = '0; handler_done = '0; clr_stats = 1'b0;
    tick;
    tick;
    chk("rst_run_handler", 32'(run_handler), 32'd0);
    chk("rst_abort", 32'(handler_abort), 32'd0);
    chk("rst_running", 32'(cmd_sm_running), 32'd0);
    chk("rst_done", 32'(cmd_sm_done), 32'd0);
    chk("rst_timeout", 32'(cmd_timeout), 32'd0);
    chk_stats("rst");
    reset = 1'b0;
    tick;

    txn(32'h2, 10, 0, 1'b0, 1'b0);
    txn(32'h7, 0, 0, 1'b0, 1'b0);
    txn(32'h1, 0, 0, 1'b0, 1'b0);
    txn(32'h1, TO, 0, 1'b0, 1'b0);
    txn(32'h3, 0, 7, 1'b0, 1'b0);
    txn(32'h0001_0001, 0, 0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a running command.
    rx_tdata = 32'h3; command_le = 1'b1;
    tick;
    command_le = 1'b0;
    tick;
    run_cmd_sm = 1'b1; handler_running = 4'b1000;
    for (int k = 0; k < 5; k++) tick;
    chk("pre_reset_run", 32'(run_handler), 32'h8);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_run", 32'(run_handler), 32'd0);
    chk("async_reset_running", 32'(cmd_sm_running), 32'd0);
    chk("async_reset_done", 32'(cmd_sm_done), 32'd0);
    illegal_m = 0; timeout_m = 0; tmo_m = 1'b0;
    chk_stats("async_reset");
    tick;
    run_cmd_sm = 1'b0; handler_running = '0; reset = 1'b0;
    tick;
    tick;
    chk("post_reset_run", 32'(run_handler), 32'd0);

    txn(32'h2, 5, 0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) txn(32'h4 + 32'(k), 0, 0, 1'b0, 1'b0);
    chk_stats("five_illegal");
    txn(32'h9, 0, 0, 1'b1, 1'b0);

    for (int r = 0; r < 30; r++) begin
      logic [31:0] code;
      int dd;
      int dp;
      code = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 5));
      dd = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
      dp = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 40) : 0;
      if (dp != 0 && dp == dd) dp = dp + 1;
      txn(code, dd, dp, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
